// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and default sizing for uart_port_arbiter and its round-robin picker.
package uart_arb_pkg;
    localparam int NREQ_DEF   = 4;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 4;
    localparam int OWNER_W    = $clog2(NREQ_DEF);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
        logic [OWNER_W-1:0]    owner;
    } cmd_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; lowest valid index at or above ptr wins, wrapping to 0.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    logic [N-1:0] upper;
    logic [N-1:0] pick;
    always_comb begin
        upper = valid & ~((N'(1) << ptr) - N'(1));
        pick  = (upper != '0) ? upper : valid;
        gnt   = pick & (~pick + N'(1));
        idx   = '0;
        for (int i = 0; i < N; i++)
            if (gnt[i]) idx = W'(i);
    end
endmodule

// File: rtl/uart_port_arbiter.sv
// uart_port_arbiter: round-robin sharing of one uart register port among NREQ requesters.
// Define UART_ARB_TIMEOUT_EN to abort transactions that see no ready within TIMEOUT_CYC cycles.
module uart_port_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ        = NREQ_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NREQ-1:0]        req_valid_i,
    input  logic [NREQ-1:0]        req_we_i,
    input  logic [NREQ*ADDR_W-1:0] req_addr_i,
    input  logic [NREQ*DATA_W-1:0] req_wdata_i,
    output logic [NREQ-1:0]        req_gnt_o,
    output logic [NREQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]      rsp_data_o,
    output logic                   rsp_err_o,
    output logic                   wr_valid_o,
    output logic [ADDR_W-1:0]      wr_addr_o,
    output logic [DATA_W-1:0]      wr_data_o,
    input  logic                   wr_ready_i,
    input  logic                   wr_err_i,
    output logic                   rd_valid_o,
    output logic [ADDR_W-1:0]      rd_addr_o,
    input  logic [DATA_W-1:0]      rd_data_i,
    input  logic                   rd_ready_i,
    input  logic                   rd_err_i,
    output logic                   busy_o
);
    // The latched command type is sized by the package, so the widths must agree with it.
    if (NREQ != NREQ_DEF || ADDR_W != ADDR_W_DEF || DATA_W != DATA_W_DEF || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("uart_port_arbiter: sizing must match uart_arb_pkg and TIMEOUT_CYC must be >= 2");
    end
    state_e             state;
    cmd_t               cmd;
    logic [OWNER_W-1:0] ptr;
    logic [OWNER_W-1:0] win_idx;
    logic [NREQ-1:0]    win_gnt;
    logic               ready;
    logic               err;
    logic               expired;
    rr_arbiter #(.N(NREQ), .W(OWNER_W)) u_rr (
        .valid(req_valid_i),
        .ptr  (ptr),
        .gnt  (win_gnt),
        .idx  (win_idx)
    );
    assign ready     = cmd.we ? wr_ready_i : rd_ready_i;
    assign err       = cmd.we ? wr_err_i : rd_err_i;
    assign wr_addr_o = cmd.addr;
    assign rd_addr_o = cmd.addr;
    assign wr_data_o = cmd.wdata;
    assign busy_o    = state != IDLE;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt;
    assign expired = cnt == CNT_W'(TIMEOUT_CYC - 1);
`else
    assign expired = 1'b0;
`endif
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            cmd         <= '0;
            ptr         <= '0;
            req_gnt_o   <= '0;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            wr_valid_o  <= 1'b0;
            rd_valid_o  <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt         <= '0;
`endif
        end else begin
            req_gnt_o   <= '0;
            rsp_valid_o <= '0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            wr_valid_o  <= 1'b0;
            rd_valid_o  <= 1'b0;
            case (state)
                IDLE: if (|req_valid_i) begin
                    cmd.we     <= req_we_i[win_idx];
                    cmd.addr   <= req_addr_i[win_idx*ADDR_W +: ADDR_W];
                    cmd.wdata  <= req_wdata_i[win_idx*DATA_W +: DATA_W];
                    cmd.owner  <= win_idx;
                    ptr        <= (win_idx == OWNER_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                    req_gnt_o  <= win_gnt;
                    wr_valid_o <= req_we_i[win_idx];
                    rd_valid_o <= !req_we_i[win_idx];
`ifdef UART_ARB_TIMEOUT_EN
                    cnt        <= '0;
`endif
                    state      <= ISSUE;
                end
                ISSUE, WAIT: if (ready || expired) begin
                    // A ready in the expiry cycle still wins over the abort.
                    rsp_valid_o <= NREQ'(1) << cmd.owner;
                    rsp_data_o  <= (ready && !cmd.we) ? rd_data_i : '0;
                    rsp_err_o   <= ready ? err : 1'b1;
                    state       <= IDLE;
                end else begin
`ifdef UART_ARB_TIMEOUT_EN
                    cnt         <= cnt + 1'b1;
`endif
                    state       <= WAIT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
